// File: rtl/odu_pkg.sv
// Shared definitions for the ODU receive checker.
// Holds the channel count, the data/cfg widths, the bit positions of the
// fields inside an ODU word, the register address map and a helper that
// checks the payload copies and the zero tail of a word.
package odu_pkg;

  localparam int NUM_CH         = 80;
  localparam int DATA_WIDTH     = 387;
  localparam int CHID_WIDTH     = 7;
  localparam int SEQ_WIDTH      = 16;
  localparam int DATA_WIDTH_CFG = 16;
  localparam int ADDR_WIDTH_CFG = 4;

  // Word layout: {chid[386:380], seq[379:364], 22 x seq[363:12], 12'h000}
  localparam int CHID_MSB   = 386;
  localparam int CHID_LSB   = 380;
  localparam int SEQ_MSB    = 379;
  localparam int SEQ_LSB    = 364;
  localparam int PAY_LSB    = 12;
  localparam int PAY_COPIES = 22;
  localparam int ZERO_MSB   = 11;

  localparam logic [SEQ_WIDTH-1:0] CNT_MAX = 16'hFFFF;

  localparam logic [ADDR_WIDTH_CFG-1:0] ADDR_CTRL    = 4'h0;
  localparam logic [ADDR_WIDTH_CFG-1:0] ADDR_CH_SEL  = 4'h1;
  localparam logic [ADDR_WIDTH_CFG-1:0] ADDR_CH_ERR  = 4'h2;
  localparam logic [ADDR_WIDTH_CFG-1:0] ADDR_CH_WRD  = 4'h3;
  localparam logic [ADDR_WIDTH_CFG-1:0] ADDR_CH_LOCK = 4'h4;
  localparam logic [ADDR_WIDTH_CFG-1:0] ADDR_GLB_ERR = 4'h5;
  localparam logic [ADDR_WIDTH_CFG-1:0] ADDR_STATUS  = 4'h6;

  // True when every payload copy equals the header SEQ and the tail is zero.
  function automatic logic payload_ok(input logic [DATA_WIDTH-1:0] w);
    logic ok;
    ok = (w[ZERO_MSB:0] == '0);
    for (int k = 0; k < PAY_COPIES; k++) begin
      if (w[PAY_LSB + SEQ_WIDTH*k +: SEQ_WIDTH] != w[SEQ_MSB:SEQ_LSB]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/odu_rx_cfg_regs.sv
// Configuration register block for the ODU receive checker.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_n_cs/n_we/n_oe          active-low chip select / write / output enable
//   cfg_addr, cfg_din, cfg_dout register address, write data, read data
//   err_event, chid_event       stage-2 events: errored word, bad channel id
//   sel_err_cnt/wrd_cnt/locked  state of the channel selected by ch_sel
//   enable, clear, ch_sel       control outputs to the checker
// Writes take effect on the clock with cs and we low; read data is
// registered and appears one cycle after cs and oe low, otherwise 0.
// The global error count and STATUS live here because they are only
// ever touched through events and cfg accesses.
module odu_rx_cfg_regs
  import odu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_n_cs,
  input  logic                      cfg_n_we,
  input  logic                      cfg_n_oe,
  input  logic [ADDR_WIDTH_CFG-1:0] cfg_addr,
  input  logic [DATA_WIDTH_CFG-1:0] cfg_din,
  output logic [DATA_WIDTH_CFG-1:0] cfg_dout,
  input  logic                      err_event,
  input  logic                      chid_event,
  input  logic [DATA_WIDTH_CFG-1:0] sel_err_cnt,
  input  logic [DATA_WIDTH_CFG-1:0] sel_wrd_cnt,
  input  logic                      sel_locked,
  output logic                      enable,
  output logic                      clear,
  output logic [CHID_WIDTH-1:0]     ch_sel
);

  logic                      wr;
  logic                      rd;
  logic [1:0]                status_q;
  logic [1:0]                w1c;
  logic [DATA_WIDTH_CFG-1:0] glb_err_q;
  logic [DATA_WIDTH_CFG-1:0] rdata;
  logic                      unused_din;

  assign wr  = !cfg_n_cs && !cfg_n_we;
  assign rd  = !cfg_n_cs && !cfg_n_oe;
  assign w1c = (wr && cfg_addr == ADDR_STATUS) ? cfg_din[1:0] : 2'b00;
  assign unused_din = ^cfg_din[DATA_WIDTH_CFG-1:CHID_WIDTH];

  always_comb begin
    rdata = '0;
    case (cfg_addr)
      ADDR_CTRL:    rdata = {{(DATA_WIDTH_CFG-1){1'b0}}, enable};
      ADDR_CH_SEL:  rdata = {{(DATA_WIDTH_CFG-CHID_WIDTH){1'b0}}, ch_sel};
      ADDR_CH_ERR:  rdata = sel_err_cnt;
      ADDR_CH_WRD:  rdata = sel_wrd_cnt;
      ADDR_CH_LOCK: rdata = {sel_locked, {(DATA_WIDTH_CFG-1){1'b0}}};
      ADDR_GLB_ERR: rdata = glb_err_q;
      ADDR_STATUS:  rdata = {{(DATA_WIDTH_CFG-2){1'b0}}, status_q};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= 1'b1;
      clear     <= 1'b0;
      ch_sel    <= '0;
      status_q  <= '0;
      glb_err_q <= '0;
      cfg_dout  <= '0;
    end else begin
      // clear is a one-cycle pulse; the checker applies it on the next edge.
      clear <= wr && cfg_addr == ADDR_CTRL && cfg_din[1];
      if (wr && cfg_addr == ADDR_CTRL)   enable <= cfg_din[0];
      if (wr && cfg_addr == ADDR_CH_SEL) ch_sel <= cfg_din[CHID_WIDTH-1:0];
      if (clear) begin
        status_q  <= '0;
        glb_err_q <= '0;
      end else begin
        // A new event overrides a simultaneous write-1-to-clear.
        status_q <= (status_q & ~w1c) | {chid_event, err_event};
        if (err_event && glb_err_q != CNT_MAX) glb_err_q <= glb_err_q + 16'd1;
      end
      cfg_dout <= rd ? rdata : '0;
    end
  end

endmodule

// File: rtl/odu_rx_check.sv
// ODU receive checker: verifies per-channel sequence numbers and word format.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid               qualifies chid_in/data_in for one cycle; there is
//                          no ready, every qualified word is accepted
//   chid_in, data_in       channel id and ODU word
//   cfg_*                  register interface (see odu_rx_cfg_regs)
//   err_pulse, err_chid    one-cycle pulse per errored word and its channel
// Stage 1 registers the input; stage 2 checks it against the channel state
// and updates that state on the same edge that raises err_pulse, so the
// pulse appears two cycles after the word is sampled. Per-channel state is
// held in flops and read combinationally, so a word directly following one
// on the same channel always sees the freshly written state.
module odu_rx_check #(
  parameter int NUM_CH         = odu_pkg::NUM_CH,
  parameter int DATA_WIDTH     = odu_pkg::DATA_WIDTH,
  parameter int CHID_WIDTH     = odu_pkg::CHID_WIDTH,
  parameter int DATA_WIDTH_CFG = odu_pkg::DATA_WIDTH_CFG,
  parameter int ADDR_WIDTH_CFG = odu_pkg::ADDR_WIDTH_CFG
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHID_WIDTH-1:0]     chid_in,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      cfg_n_cs,
  input  logic                      cfg_n_we,
  input  logic                      cfg_n_oe,
  input  logic [ADDR_WIDTH_CFG-1:0] cfg_addr,
  input  logic [DATA_WIDTH_CFG-1:0] cfg_din,
  output logic [DATA_WIDTH_CFG-1:0] cfg_dout,
  output logic                      err_pulse,
  output logic [CHID_WIDTH-1:0]     err_chid
);
  import odu_pkg::*;

  logic                  enable;
  logic                  clear;
  logic [CHID_WIDTH-1:0] ch_sel;

  logic                  s1_valid;
  logic [CHID_WIDTH-1:0] s1_chid;
  logic [DATA_WIDTH-1:0] s1_data;

  logic                  locked_q  [NUM_CH];
  logic [SEQ_WIDTH-1:0]  exp_seq_q [NUM_CH];
  logic [SEQ_WIDTH-1:0]  err_cnt_q [NUM_CH];
  logic [SEQ_WIDTH-1:0]  wrd_cnt_q [NUM_CH];

  logic                  chid_ok;
  logic [CHID_WIDTH-1:0] idx;
  logic [SEQ_WIDTH-1:0]  word_seq;
  logic                  mismatch;
  logic                  word_ok;
  logic                  err_ev;
  logic                  chid_ev;

  logic                  sel_ok;
  logic [CHID_WIDTH-1:0] sel_idx;
  logic [SEQ_WIDTH-1:0]  sel_err_cnt;
  logic [SEQ_WIDTH-1:0]  sel_wrd_cnt;
  logic                  sel_locked;

  // Stage 1: input register; disabled traffic never enters the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_chid  <= '0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid && enable;
      if (in_valid) begin
        s1_chid <= chid_in;
        s1_data <= data_in;
      end
    end
  end

  // Stage 2: check. idx is forced in range so the array read stays legal.
  assign chid_ok  = int'(s1_chid) < NUM_CH;
  assign idx      = chid_ok ? s1_chid : '0;
  assign word_seq = s1_data[SEQ_MSB:SEQ_LSB];
  assign mismatch = (word_seq != exp_seq_q[idx]) ||
                    (s1_data[CHID_MSB:CHID_LSB] != s1_chid) ||
                    !payload_ok(s1_data);
  // A pending clear discards whatever word sits in stage 2.
  assign word_ok  = s1_valid && !clear && chid_ok;
  assign err_ev   = word_ok && locked_q[idx] && mismatch;
  assign chid_ev  = s1_valid && !clear && !chid_ok;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        locked_q[i]  <= 1'b0;
        exp_seq_q[i] <= '0;
        err_cnt_q[i] <= '0;
        wrd_cnt_q[i] <= '0;
      end
    end else if (word_ok) begin
      // Resync on every word, good or bad.
      locked_q[idx]  <= 1'b1;
      exp_seq_q[idx] <= word_seq + 16'd1;
      wrd_cnt_q[idx] <= wrd_cnt_q[idx] + 16'd1;
      if (err_ev && err_cnt_q[idx] != CNT_MAX) err_cnt_q[idx] <= err_cnt_q[idx] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_chid  <= '0;
    end else begin
      err_pulse <= err_ev;
      if (err_ev) err_chid <= s1_chid;
    end
  end

  assign sel_ok      = int'(ch_sel) < NUM_CH;
  assign sel_idx     = sel_ok ? ch_sel : '0;
  assign sel_err_cnt = sel_ok ? err_cnt_q[sel_idx] : '0;
  assign sel_wrd_cnt = sel_ok ? wrd_cnt_q[sel_idx] : '0;
  assign sel_locked  = sel_ok && locked_q[sel_idx];

  odu_rx_cfg_regs u_cfg (
    .clk         (clk),
    .rst         (rst),
    .cfg_n_cs    (cfg_n_cs),
    .cfg_n_we    (cfg_n_we),
    .cfg_n_oe    (cfg_n_oe),
    .cfg_addr    (cfg_addr),
    .cfg_din     (cfg_din),
    .cfg_dout    (cfg_dout),
    .err_event   (err_ev),
    .chid_event  (chid_ev),
    .sel_err_cnt (sel_err_cnt),
    .sel_wrd_cnt (sel_wrd_cnt),
    .sel_locked  (sel_locked),
    .enable      (enable),
    .clear       (clear),
    .ch_sel      (ch_sel)
  );

endmodule

// File: tb/tb_odu_rx_check.sv
module tb_odu_rx_check;

  localparam int NCH = 80;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [6:0]   chid_in = '0;
  logic [386:0] data_in = '0;
  logic         cfg_n_cs = 1'b1;
  logic         cfg_n_we = 1'b1;
  logic         cfg_n_oe = 1'b1;
  logic [3:0]   cfg_addr = '0;
  logic [15:0]  cfg_din = '0;
  logic [15:0]  cfg_dout;
  logic         err_pulse;
  logic [6:0]   err_chid;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  odu_rx_check dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .chid_in (chid_in), .data_in (data_in),
    .cfg_n_cs (cfg_n_cs), .cfg_n_we (cfg_n_we), .cfg_n_oe (cfg_n_oe),
    .cfg_addr (cfg_addr), .cfg_din (cfg_din), .cfg_dout (cfg_dout),
    .err_pulse (err_pulse), .err_chid (err_chid)
  );

  // reference model: a word on a locked channel is good iff it equals the
  // canonical word built from its channel id and the expected SEQ
  logic        m_locked [NCH];
  logic [15:0] m_exp [NCH];
  logic [15:0] m_err [NCH];
  logic [15:0] m_wrd [NCH];
  logic [15:0] m_glob;
  logic [1:0]  m_status;
  logic        m_en;

  // scoreboard: per-cycle {err_pulse, err_chid} expected vs observed
  logic [7:0]   exp_q[$];
  logic [7:0]   obs_q[$];
  logic         st_v[$];
  logic [6:0]   st_c[$];
  logic [386:0] st_d[$];

  function automatic logic [386:0] make_word(input logic [6:0] c, input logic [15:0] s);
    logic [386:0] w;
    w = '0;
    w[386:380] = c;
    w[379:364] = s;
    for (int k = 0; k < 22; k++) w[12 + 16*k +: 16] = s;
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_locked[i] = 1'b0; m_exp[i] = '0; m_err[i] = '0; m_wrd[i] = '0;
    end
    m_glob = '0; m_status = '0; m_en = 1'b1;
  endtask

  function automatic logic [7:0] model_word(input logic [6:0] c, input logic [386:0] d);
    logic bad;
    if (!m_en) return 8'h00;
    if (int'(c) >= NCH) begin
      m_status[1] = 1'b1;
      return 8'h00;
    end
    bad = m_locked[c] && (d != make_word(c, m_exp[c]));
    m_locked[c] = 1'b1;
    m_exp[c] = d[379:364] + 16'd1;
    m_wrd[c] = m_wrd[c] + 16'd1;
    if (bad) begin
      if (m_err[c] != 16'hFFFF) m_err[c] = m_err[c] + 16'd1;
      if (m_glob != 16'hFFFF) m_glob = m_glob + 16'd1;
      m_status[0] = 1'b1;
    end
    return bad ? {1'b1, c} : 8'h00;
  endfunction

  // driver tasks
  task automatic start_stream();
    st_v.delete(); st_c.delete(); st_d.delete(); obs_q.delete(); exp_q.delete();
    exp_q.push_back(8'h00);
  endtask

  task automatic push_word(input logic v, input logic [6:0] c, input logic [386:0] d);
    st_v.push_back(v); st_c.push_back(c); st_d.push_back(d);
    exp_q.push_back(v ? model_word(c, d) : 8'h00);
  endtask

  task automatic drive_stream();
    for (int i = 0; i < st_v.size(); i++) begin
      in_valid = st_v[i]; chid_in = st_c[i]; data_in = st_d[i];
      @(negedge clk);
      obs_q.push_back({err_pulse, err_chid});
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      obs_q.push_back({err_pulse, err_chid});
    end
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_n_cs = 1'b0; cfg_n_we = 1'b0; cfg_addr = a; cfg_din = d;
    @(negedge clk);
    cfg_n_cs = 1'b1; cfg_n_we = 1'b1;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [15:0] d);
    cfg_n_cs = 1'b0; cfg_n_oe = 1'b0; cfg_addr = a;
    @(negedge clk);
    d = cfg_dout;
    cfg_n_cs = 1'b1; cfg_n_oe = 1'b1;
  endtask

  task automatic read_ch(input logic [6:0] c, output logic [15:0] e, output logic [15:0] w,
                         output logic [15:0] l);
    cfg_write(4'h1, {9'b0, c});
    cfg_read(4'h2, e);
    cfg_read(4'h3, w);
    cfg_read(4'h4, l);
  endtask

  // tests
  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (err_pulse !== 1'b0 || err_chid !== 7'd0 || cfg_dout !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs: got pulse=%0b chid=%0d dout=%h want 0/0/0", err_pulse, err_chid, cfg_dout);
    end
    for (int a = 0; a < 8; a++) begin
      cfg_read(4'(a), v);
      checks++;
      if (v !== ((a == 0) ? 16'h0001 : 16'h0000)) begin
        failures++;
        $display("FAIL reset_reg%0d: got %h want %h", a, v, (a == 0) ? 16'h0001 : 16'h0000);
      end
    end
    @(negedge clk);
    checks++;
    if (cfg_dout !== 16'h0000) begin
      failures++;
      $display("FAIL dout_idle: got %h want 0000", cfg_dout);
    end
  endtask

  task automatic test_valid_seq();
    logic [15:0] e, w, l;
    start_stream();
    for (int s = 16'h10; s <= 16'h14; s++) push_word(1'b1, 7'd5, make_word(7'd5, 16'(s)));
    drive_stream();
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k][7] !== exp_q[k][7] || (exp_q[k][7] && obs_q[k][6:0] !== exp_q[k][6:0])) begin
        failures++;
        $display("FAIL valid_seq_pulse cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    read_ch(7'd5, e, w, l);
    checks++;
    if (e !== m_err[5] || w !== m_wrd[5] || l !== {m_locked[5], 15'b0}) begin
      failures++;
      $display("FAIL valid_seq_stats: got err=%h wrd=%h lock=%h want %h %h %h",
               e, w, l, m_err[5], m_wrd[5], {m_locked[5], 15'b0});
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e, w, l;
    start_stream();
    push_word(1'b1, 7'd79, make_word(7'd79, 16'hFFFE));
    push_word(1'b1, 7'd79, make_word(7'd79, 16'hFFFF));
    push_word(1'b1, 7'd79, make_word(7'd79, 16'h0000));
    push_word(1'b1, 7'd79, make_word(7'd79, 16'h0002));
    push_word(1'b1, 7'd79, make_word(7'd79, 16'h0003));
    drive_stream();
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k][7] !== exp_q[k][7] || (exp_q[k][7] && obs_q[k][6:0] !== exp_q[k][6:0])) begin
        failures++;
        $display("FAIL wrap_pulse cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    read_ch(7'd79, e, w, l);
    checks++;
    if (e !== m_err[79] || w !== m_wrd[79]) begin
      failures++;
      $display("FAIL wrap_stats: got err=%h wrd=%h want %h %h", e, w, m_err[79], m_wrd[79]);
    end
  endtask

  task automatic test_payload_err();
    logic [15:0] v;
    logic [386:0] d;
    logic [7:0] ex;
    start_stream();
    push_word(1'b1, 7'd3, make_word(7'd3, 16'h0100));
    d = make_word(7'd3, 16'h0101);
    d[100] = ~d[100];
    push_word(1'b1, 7'd3, d);
    drive_stream();
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k][7] !== exp_q[k][7] || (exp_q[k][7] && obs_q[k][6:0] !== exp_q[k][6:0])) begin
        failures++;
        $display("FAIL payload_pulse cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    cfg_read(4'h5, v);
    checks++;
    if (v !== m_glob) begin failures++; $display("FAIL glob_cnt: got %h want %h", v, m_glob); end
    cfg_read(4'h6, v);
    checks++;
    if (v !== {14'b0, m_status}) begin failures++; $display("FAIL status_err: got %h want %h", v, m_status); end
    cfg_write(4'h6, 16'h0001);
    m_status[0] = 1'b0;
    cfg_read(4'h6, v);
    checks++;
    if (v !== {14'b0, m_status}) begin failures++; $display("FAIL status_w1c: got %h want %h", v, m_status); end
    // error event and W1C of bit 0 land on the same edge
    d = make_word(7'd3, m_exp[3]);
    d[12] = ~d[12];
    in_valid = 1'b1; chid_in = 7'd3; data_in = d;
    @(negedge clk);
    in_valid = 1'b0;
    ex = model_word(7'd3, d);
    cfg_write(4'h6, 16'h0001);
    checks++;
    if (err_pulse !== ex[7] || err_chid !== ex[6:0]) begin
      failures++;
      $display("FAIL w1c_race_pulse: got %0b/%0d want %0b/%0d", err_pulse, err_chid, ex[7], ex[6:0]);
    end
    cfg_read(4'h6, v);
    checks++;
    if (v !== {14'b0, m_status}) begin failures++; $display("FAIL status_race: got %h want %h", v, m_status); end
    cfg_write(4'h6, 16'h0001);
    m_status[0] = 1'b0;
  endtask

  task automatic test_bad_chid();
    logic [15:0] v;
    start_stream();
    push_word(1'b1, 7'd80, make_word(7'd80, 16'h1234));
    push_word(1'b1, 7'd127, make_word(7'd0, 16'h0001));
    drive_stream();
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k][7] !== exp_q[k][7]) begin
        failures++;
        $display("FAIL bad_chid_pulse cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    cfg_read(4'h6, v);
    checks++;
    if (v !== {14'b0, m_status}) begin failures++; $display("FAIL status_chid: got %h want %h", v, m_status); end
    cfg_read(4'h5, v);
    checks++;
    if (v !== m_glob) begin failures++; $display("FAIL glob_after_chid: got %h want %h", v, m_glob); end
    cfg_write(4'h6, 16'h0002);
    m_status[1] = 1'b0;
    // out-of-range channel select reads zero
    cfg_write(4'h1, 16'd100);
    cfg_read(4'h1, v);
    checks++;
    if (v !== 16'd100) begin failures++; $display("FAIL ch_sel_rb: got %h want 0064", v); end
    for (int a = 2; a <= 4; a++) begin
      cfg_read(4'(a), v);
      checks++;
      if (v !== 16'h0000) begin failures++; $display("FAIL sel_oor_reg%0d: got %h want 0000", a, v); end
    end
  endtask

  task automatic test_enable();
    logic [15:0] e, w, l;
    cfg_write(4'h0, 16'h0000);
    m_en = 1'b0;
    start_stream();
    push_word(1'b1, 7'd5, make_word(7'd5, 16'h7777));
    push_word(1'b1, 7'd81, make_word(7'd81, 16'h0000));
    drive_stream();
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k][7] !== exp_q[k][7]) begin
        failures++;
        $display("FAIL disabled_pulse cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    read_ch(7'd5, e, w, l);
    checks++;
    if (e !== m_err[5] || w !== m_wrd[5]) begin
      failures++;
      $display("FAIL disabled_stats: got err=%h wrd=%h want %h %h", e, w, m_err[5], m_wrd[5]);
    end
    cfg_write(4'h0, 16'h0001);
    m_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e, w, l;
    start_stream();
    for (int s = 1; s <= 3; s++) push_word(1'b1, 7'd0, make_word(7'd0, 16'(s)));
    for (int s = 4; s <= 6; s++) begin
      push_word(1'b1, 7'd0, make_word(7'd0, 16'(s)));
      push_word(1'b1, 7'd1, make_word(7'd1, 16'(s + 6)));
    end
    push_word(1'b1, 7'd1, make_word(7'd1, 16'd12));
    push_word(1'b1, 7'd1, make_word(7'd1, 16'd12));
    drive_stream();
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k][7] !== exp_q[k][7] || (exp_q[k][7] && obs_q[k][6:0] !== exp_q[k][6:0])) begin
        failures++;
        $display("FAIL b2b_pulse cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    read_ch(7'd0, e, w, l);
    checks++;
    if (e !== m_err[0] || w !== m_wrd[0]) begin
      failures++;
      $display("FAIL b2b_stats: got err=%h wrd=%h want %h %h", e, w, m_err[0], m_wrd[0]);
    end
  endtask

  task automatic test_clear();
    logic [15:0] v, e, w, l;
    // mis-sequenced word on ch0 sits in stage 2 while clear is pending
    in_valid = 1'b1; chid_in = 7'd0; data_in = make_word(7'd0, 16'h0050);
    cfg_n_cs = 1'b0; cfg_n_we = 1'b0; cfg_addr = 4'h0; cfg_din = 16'h0003;
    @(negedge clk);
    in_valid = 1'b0; cfg_n_cs = 1'b1; cfg_n_we = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (err_pulse !== 1'b0) begin failures++; $display("FAIL clear_pulse: got %0b want 0", err_pulse); end
    end
    read_ch(7'd0, e, w, l);
    checks++;
    if (e !== m_err[0] || w !== m_wrd[0] || l !== {m_locked[0], 15'b0}) begin
      failures++;
      $display("FAIL clear_ch0: got err=%h wrd=%h lock=%h want 0 0 0", e, w, l);
    end
    cfg_read(4'h5, v);
    checks++;
    if (v !== m_glob) begin failures++; $display("FAIL clear_glob: got %h want %h", v, m_glob); end
    read_ch(7'd79, e, w, l);
    checks++;
    if (e !== m_err[79] || w !== m_wrd[79]) begin
      failures++;
      $display("FAIL clear_ch79: got err=%h wrd=%h want 0 0", e, w);
    end
    cfg_read(4'h0, v);
    checks++;
    if (v !== 16'h0001) begin failures++; $display("FAIL clear_ctrl: got %h want 0001", v); end
    start_stream();
    push_word(1'b1, 7'd0, make_word(7'd0, 16'h0050));
    drive_stream();
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k][7] !== exp_q[k][7]) begin
        failures++;
        $display("FAIL relock_pulse cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] e, w, l, s, v;
    logic [6:0] c;
    logic [386:0] d;
    start_stream();
    for (int i = 0; i < 80; i++) begin
      c = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(60, 63));
      s = 16'($urandom);
      if (int'(c) < NCH && $urandom_range(0, 3) != 0) s = m_exp[c];
      d = make_word(c, s);
      if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 386)] ^= 1'b1;
      push_word($urandom_range(0, 4) != 0, c, d);
    end
    drive_stream();
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k][7] !== exp_q[k][7] || (exp_q[k][7] && obs_q[k][6:0] !== exp_q[k][6:0])) begin
        failures++;
        $display("FAIL rand_pulse cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    for (int ch = 60; ch <= 63; ch++) begin
      read_ch(7'(ch), e, w, l);
      checks++;
      if (e !== m_err[ch] || w !== m_wrd[ch] || l !== {m_locked[ch], 15'b0}) begin
        failures++;
        $display("FAIL rand_ch%0d: got err=%h wrd=%h lock=%h want %h %h %h",
                 ch, e, w, l, m_err[ch], m_wrd[ch], {m_locked[ch], 15'b0});
      end
    end
    cfg_read(4'h5, v);
    checks++;
    if (v !== m_glob) begin failures++; $display("FAIL rand_glob: got %h want %h", v, m_glob); end
    cfg_read(4'h6, v);
    checks++;
    if (v !== {14'b0, m_status}) begin failures++; $display("FAIL rand_status: got %h want %h", v, m_status); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v, e, w, l;
    // word with a wrong SEQ on a locked channel, killed in stage 2 by rst
    in_valid = 1'b1; chid_in = 7'd60; data_in = make_word(7'd60, m_exp[60] + 16'd5);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) begin
      checks++;
      if (err_pulse !== 1'b0) begin failures++; $display("FAIL rst_mid_pulse: got %0b want 0", err_pulse); end
      @(negedge clk);
    end
    for (int a = 0; a < 16; a++) begin
      cfg_read(4'(a), v);
      checks++;
      if (v !== ((a == 0) ? 16'h0001 : 16'h0000)) begin
        failures++;
        $display("FAIL rst_mid_reg%0d: got %h want %h", a, v, (a == 0) ? 16'h0001 : 16'h0000);
      end
    end
    start_stream();
    push_word(1'b1, 7'd60, make_word(7'd60, 16'($urandom)));
    push_word(1'b1, 7'd61, make_word(7'd61, 16'($urandom)));
    push_word(1'b1, 7'd79, make_word(7'd79, 16'($urandom)));
    drive_stream();
    for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k][7] !== exp_q[k][7]) begin
        failures++;
        $display("FAIL rst_relock_pulse cyc%0d: got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    read_ch(7'd79, e, w, l);
    checks++;
    if (e !== m_err[79] || w !== m_wrd[79] || l !== {m_locked[79], 15'b0}) begin
      failures++;
      $display("FAIL rst_relock_stats: got err=%h wrd=%h lock=%h want %h %h %h",
               e, w, l, m_err[79], m_wrd[79], {m_locked[79], 15'b0});
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_valid_seq();
    test_wrap();
    test_payload_err();
    test_bad_chid();
    test_enable();
    test_back_to_back();
    test_clear();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
